data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 26 ++
 rtl/data_mem_arbiter_if.sv | 59 +++++
 rtl/data_mem_arbiter_rtrack.sv | 60 ++++++
 rtl/data_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared types for the data-memory arbiter: arbitration FSM
//             states, requester identifiers and access-size encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        CPU_PRI    = 2'd0,
        DMA_PRI    = 2'd1,
        DMA_LOCKED = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter_if
//  Purpose  : Bundles the CPU, DMA and data-memory buses of the arbiter.
//  Ports    : slave  - arbiter view (requests/mem_rdata in, grants/mem out)
//             master - environment view (the mirror of slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if #(
    parameter int DATA_W = 32
);
    // CPU side
    logic              cpu_req_in;
    logic              cpu_we_in;
    logic [DATA_W-1:0] cpu_addr_in;
    logic [DATA_W-1:0] cpu_wdata_in;
    logic [1:0]        cpu_size_in;
    logic              cpu_gnt_out;
    logic              cpu_stall_out;
    logic              cpu_rvalid_out;
    logic [DATA_W-1:0] cpu_rdata_out;
    // DMA side
    logic              dma_req_in;
    logic              dma_we_in;
    logic              dma_lock_in;
    logic [DATA_W-1:0] dma_addr_in;
    logic [DATA_W-1:0] dma_wdata_in;
    logic [1:0]        dma_size_in;
    logic              dma_gnt_out;
    logic              dma_rvalid_out;
    logic [DATA_W-1:0] dma_rdata_out;
    // Memory side
    logic [DATA_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic [1:0]        mem_size_out;
    logic              mem_re_out;
    logic              mem_we_out;
    logic [DATA_W-1:0] mem_rdata_in;

    modport slave (
        input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in, cpu_size_in,
        output cpu_gnt_out, cpu_stall_out, cpu_rvalid_out, cpu_rdata_out,
        input  dma_req_in, dma_we_in, dma_lock_in, dma_addr_in, dma_wdata_in, dma_size_in,
        output dma_gnt_out, dma_rvalid_out, dma_rdata_out,
        output mem_addr_out, mem_wdata_out, mem_size_out, mem_re_out, mem_we_out,
        input  mem_rdata_in
    );

    modport master (
        output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in, cpu_size_in,
        input  cpu_gnt_out, cpu_stall_out, cpu_rvalid_out, cpu_rdata_out,
        output dma_req_in, dma_we_in, dma_lock_in, dma_addr_in, dma_wdata_in, dma_size_in,
        input  dma_gnt_out, dma_rvalid_out, dma_rdata_out,
        input  mem_addr_out, mem_wdata_out, mem_size_out, mem_re_out, mem_we_out,
        output mem_rdata_in
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter_rtrack.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_rtrack
//  Purpose  : One-entry owner tag for read returns. Memory data arrives one
//             cycle after an issued load and is steered to the requester that
//             issued it; the other rvalid/rdata stay 0.
//  Ports    : clock, reset         - clock, synchronous active-high reset
//             issue_load_in        - a load is issued this cycle
//             issue_owner_in       - who issued it
//             mem_rdata_in         - memory read data
//             cpu_/dma_rvalid_out  - load return strobe per requester
//             cpu_/dma_rdata_out   - load return data (0 when not valid)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rtrack
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              issue_load_in,
    input  wire req_id_e           issue_owner_in,
    input  wire logic [DATA_W-1:0] mem_rdata_in,
    output logic                   cpu_rvalid_out,
    output logic [DATA_W-1:0]      cpu_rdata_out,
    output logic                   dma_rvalid_out,
    output logic [DATA_W-1:0]      dma_rdata_out
);

    logic    tag_valid_q, tag_valid_d;
    req_id_e tag_owner_q, tag_owner_d;

    // The tag only ever describes the load issued in the previous cycle,
    // so it is simply overwritten every cycle.
    always_comb begin
        tag_valid_d = issue_load_in;
        tag_owner_d = issue_owner_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid_q <= 1'b0;
            tag_owner_q <= REQ_CPU;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_owner_q <= tag_owner_d;
        end
    end

    // Returns are suppressed while reset is high so every output reads 0.
    always_comb begin
        cpu_rvalid_out = tag_valid_q && (tag_owner_q == REQ_CPU) && !reset;
        dma_rvalid_out = tag_valid_q && (tag_owner_q == REQ_DMA) && !reset;
        cpu_rdata_out  = cpu_rvalid_out ? mem_rdata_in : '0;
        dma_rdata_out  = dma_rvalid_out ? mem_rdata_in : '0;
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_arbiter
//  Purpose  : Arbitrates a CPU and a DMA engine onto a single data-memory
//             port. CPU has priority, but a DMA that keeps losing is promoted
//             after STARVE_LIMIT losses; a locked DMA issue holds the port
//             until lock or request drops.
//  Ports    : clock, reset - clock, synchronous active-high reset
//             bus          - CPU / DMA / memory signals (slave modport)
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  wire logic         clock,
    input  wire logic         reset,
    data_mem_arbiter_if.slave bus
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             cpu_gnt, dma_gnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= CPU_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;

        case (state_q)
            CPU_PRI: begin
                if (bus.cpu_req_in) begin
                    cpu_gnt = 1'b1;
                    if (bus.dma_req_in) begin
                        if (starve_q != C_LIMIT) begin
                            starve_d = starve_q + 1'b1;
                        end
                        if (starve_d == C_LIMIT) begin
                            state_d = DMA_PRI;
                        end
                    end
                end else if (bus.dma_req_in) begin
                    dma_gnt = 1'b1;
                end
            end
            DMA_PRI: begin
                if (bus.dma_req_in) begin
                    dma_gnt = 1'b1;
                end else if (bus.cpu_req_in) begin
                    cpu_gnt = 1'b1;
                end
            end
            DMA_LOCKED: begin
                // The cycle the lock (or request) drops is a dead cycle:
                // nobody is granted and the CPU wins from the next cycle.
                if (bus.dma_req_in && bus.dma_lock_in) begin
                    dma_gnt = 1'b1;
                end else begin
                    state_d  = CPU_PRI;
                    starve_d = '0;
                end
            end
            default: begin
                state_d  = CPU_PRI;
                starve_d = '0;
            end
        endcase

        if (dma_gnt) begin
            starve_d = '0;
            if (bus.dma_lock_in) begin
                state_d = DMA_LOCKED;
            end else begin
                state_d = CPU_PRI;
            end
        end

        if (reset) begin
            cpu_gnt = 1'b0;
            dma_gnt = 1'b0;
        end
    end

    // Memory port: driven by whichever request is issued, all-zero when idle.
    always_comb begin
        bus.mem_addr_out  = '0;
        bus.mem_wdata_out = '0;
        bus.mem_size_out  = '0;
        bus.mem_re_out    = 1'b0;
        bus.mem_we_out    = 1'b0;
        if (cpu_gnt) begin
            bus.mem_addr_out  = bus.cpu_addr_in;
            bus.mem_wdata_out = bus.cpu_wdata_in;
            bus.mem_size_out  = bus.cpu_size_in;
            bus.mem_re_out    = !bus.cpu_we_in;
            bus.mem_we_out    = bus.cpu_we_in;
        end else if (dma_gnt) begin
            bus.mem_addr_out  = bus.dma_addr_in;
            bus.mem_wdata_out = bus.dma_wdata_in;
            bus.mem_size_out  = bus.dma_size_in;
            bus.mem_re_out    = !bus.dma_we_in;
            bus.mem_we_out    = bus.dma_we_in;
        end
    end

    always_comb begin
        bus.cpu_gnt_out   = cpu_gnt;
        bus.dma_gnt_out   = dma_gnt;
        bus.cpu_stall_out = bus.cpu_req_in && !cpu_gnt;
    end

    logic              cpu_rvalid, dma_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dma_rdata;

    mem_arb_rtrack #(
        .DATA_W (DATA_W)
    ) u_rtrack (
        .clock          (clock),
        .reset          (reset),
        .issue_load_in  ((cpu_gnt && !bus.cpu_we_in) || (dma_gnt && !bus.dma_we_in)),
        .issue_owner_in (dma_gnt ? REQ_DMA : REQ_CPU),
        .mem_rdata_in   (bus.mem_rdata_in),
        .cpu_rvalid_out (cpu_rvalid),
        .cpu_rdata_out  (cpu_rdata),
        .dma_rvalid_out (dma_rvalid),
        .dma_rdata_out  (dma_rdata)
    );

    always_comb begin
        bus.cpu_rvalid_out = cpu_rvalid;
        bus.cpu_rdata_out  = cpu_rdata;
        bus.dma_rvalid_out = dma_rvalid;
        bus.dma_rdata_out  = dma_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_arbiter
//  Purpose  : Directed self-checking bench for data_mem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.DATA_W(32)) bus ();

    data_mem_arbiter #(
        .STARVE_LIMIT (4),
        .DATA_W       (32)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c_req, input logic c_we, input logic [31:0] c_addr,
                         input logic d_req, input logic d_we, input logic d_lock,
                         input logic [31:0] d_addr, input logic [31:0] rdata);
        bus.cpu_req_in   = c_req;
        bus.cpu_we_in    = c_we;
        bus.cpu_addr_in  = c_addr;
        bus.cpu_wdata_in = c_addr ^ 32'h1111_0000;
        bus.cpu_size_in  = SIZE_WORD;
        bus.dma_req_in   = d_req;
        bus.dma_we_in    = d_we;
        bus.dma_lock_in  = d_lock;
        bus.dma_addr_in  = d_addr;
        bus.dma_wdata_in = d_addr ^ 32'h2222_0000;
        bus.dma_size_in  = SIZE_HALF;
        bus.mem_rdata_in = rdata;
        #1;
    endtask

    // Continuous-contention expectations (1 = CPU granted, else DMA).
    logic [9:0] starve_cpu_exp;
    // Lock burst: CPU grant, DMA grant, CPU stall and DMA request/lock per cycle.
    logic [8:0] lk_cpu_exp, lk_dma_exp, lk_stall_exp, lk_dreq;

    initial begin
        starve_cpu_exp = 10'b01111_01111;   // bit i = cycle i
        lk_cpu_exp     = 9'b1_0000_1111;
        lk_dma_exp     = 9'b0_0111_0000;
        lk_stall_exp   = 9'b0_1111_0000;
        lk_dreq        = 9'b0_0111_1111;

        // ---------------- Reset with requests pending ----------------
        drive(1, 0, 32'h10, 1, 0, 0, 32'h40, 32'h0);
        next_cycle();
        drive(1, 0, 32'h10, 1, 0, 0, 32'h40, 32'h0);
        chk("rst_cpu_gnt", bus.cpu_gnt_out, 0);
        chk("rst_dma_gnt", bus.dma_gnt_out, 0);
        chk("rst_mem_re", bus.mem_re_out, 0);
        chk("rst_mem_addr", bus.mem_addr_out, 0);
        chk("rst_cpu_rvalid", bus.cpu_rvalid_out, 0);

        // Load requested in the reset cycle must never return.
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h1234);
        chk("rstld_cpu_rvalid", bus.cpu_rvalid_out, 0);
        chk("rstld_state", dut.state_q, CPU_PRI);
        chk("rstld_starve", dut.starve_q, 0);

        // Load issued, then reset lands on the return cycle.
        next_cycle();
        drive(1, 0, 32'h14, 0, 0, 0, 32'h0, 32'h0);
        chk("pre_rst_gnt", bus.cpu_gnt_out, 1);
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h5555);
        chk("rst_ret_rvalid", bus.cpu_rvalid_out, 0);
        chk("rst_ret_rdata", bus.cpu_rdata_out, 0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h5555);
        chk("post_rst_rvalid", bus.cpu_rvalid_out, 0);

        // ---------------- Idle ----------------
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        chk("idle_re", bus.mem_re_out, 0);
        chk("idle_we", bus.mem_we_out, 0);
        chk("idle_cpu_gnt", bus.cpu_gnt_out, 0);
        chk("idle_dma_gnt", bus.dma_gnt_out, 0);
        chk("idle_rvalid", {bus.cpu_rvalid_out, bus.dma_rvalid_out}, 0);

        // ---------------- CPU-only load ----------------
        next_cycle();
        drive(1, 0, 32'h10, 0, 0, 0, 32'h0, 32'h0);
        chk("cld_gnt", bus.cpu_gnt_out, 1);
        chk("cld_stall", bus.cpu_stall_out, 0);
        chk("cld_re", bus.mem_re_out, 1);
        chk("cld_we", bus.mem_we_out, 0);
        chk("cld_addr", bus.mem_addr_out, 32'h10);
        chk("cld_size", bus.mem_size_out, SIZE_WORD);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'hDEADBEEF);
        chk("cld_rvalid", bus.cpu_rvalid_out, 1);
        chk("cld_rdata", bus.cpu_rdata_out, 32'hDEADBEEF);
        chk("cld_dma_rvalid", bus.dma_rvalid_out, 0);
        chk("cld_dma_rdata", bus.dma_rdata_out, 0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'hDEADBEEF);
        chk("cld_rvalid_once", bus.cpu_rvalid_out, 0);

        // ---------------- Continuous contention (stores) ----------------
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive(1, 1, 32'h100 + i, 1, 1, 0, 32'h200 + i, 32'h0);
            chk($sformatf("starve_cpu_gnt_%0d", i), bus.cpu_gnt_out, starve_cpu_exp[i]);
            chk($sformatf("starve_dma_gnt_%0d", i), bus.dma_gnt_out, !starve_cpu_exp[i]);
            chk($sformatf("starve_stall_%0d", i), bus.cpu_stall_out, !starve_cpu_exp[i]);
            chk($sformatf("starve_addr_%0d", i), bus.mem_addr_out,
                starve_cpu_exp[i] ? 32'h100 + i : 32'h200 + i);
            chk($sformatf("starve_we_%0d", i), {bus.mem_we_out, bus.mem_re_out}, 2'b10);
        end
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        chk("starve_no_rvalid", {bus.cpu_rvalid_out, bus.dma_rvalid_out}, 0);
        chk("starve_cnt_clear", dut.starve_q, 0);

        // ---------------- Locked DMA burst ----------------
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            drive(1, 1, 32'h300 + i, lk_dreq[i], 1, lk_dreq[i], 32'h400 + i, 32'h0);
            chk($sformatf("lock_cpu_gnt_%0d", i), bus.cpu_gnt_out, lk_cpu_exp[i]);
            chk($sformatf("lock_dma_gnt_%0d", i), bus.dma_gnt_out, lk_dma_exp[i]);
            chk($sformatf("lock_stall_%0d", i), bus.cpu_stall_out, lk_stall_exp[i]);
            if (i == 5) chk("lock_state", dut.state_q, DMA_LOCKED);
        end
        chk("lock_exit_starve", dut.starve_q, 0);

        // ---------------- Alternating loads ----------------
        next_cycle();
        drive(1, 0, 32'h20, 0, 0, 0, 32'h40, 32'h0);
        chk("alt1_cpu_gnt", bus.cpu_gnt_out, 1);
        chk("alt1_addr", bus.mem_addr_out, 32'h20);
        next_cycle();
        drive(0, 0, 32'h20, 1, 0, 0, 32'h40, 32'hA0A0_A0A0);
        chk("alt2_dma_gnt", bus.dma_gnt_out, 1);
        chk("alt2_addr", bus.mem_addr_out, 32'h40);
        chk("alt2_re", bus.mem_re_out, 1);
        chk("alt2_cpu_rvalid", bus.cpu_rvalid_out, 1);
        chk("alt2_cpu_rdata", bus.cpu_rdata_out, 32'hA0A0_A0A0);
        chk("alt2_dma_rvalid", bus.dma_rvalid_out, 0);
        next_cycle();
        drive(1, 0, 32'h20, 0, 0, 0, 32'h40, 32'hB0B0_B0B0);
        chk("alt3_cpu_gnt", bus.cpu_gnt_out, 1);
        chk("alt3_dma_rvalid", bus.dma_rvalid_out, 1);
        chk("alt3_dma_rdata", bus.dma_rdata_out, 32'hB0B0_B0B0);
        chk("alt3_cpu_rvalid", bus.cpu_rvalid_out, 0);
        chk("alt3_cpu_rdata", bus.cpu_rdata_out, 0);
        next_cycle();
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'hC0C0_C0C0);
        chk("alt4_cpu_rvalid", bus.cpu_rvalid_out, 1);
        chk("alt4_cpu_rdata", bus.cpu_rdata_out, 32'hC0C0_C0C0);
        chk("alt4_dma_rvalid", bus.dma_rvalid_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
